// File: rtl/mr_wb_sram_if.sv
// Wishbone B4 pipelined bus bundle between an mr_core master port and the mr_wb_sram responder.
`ifndef XLEN
`define XLEN 32
`endif

interface mr_wb_sram_if;
   logic [`XLEN-1:0]   wbs_adr_i;
   logic [`XLEN-1:0]   wbs_dat_i;
   logic [`XLEN-1:0]   wbs_dat_o;
   logic               wbs_we_i;
   logic [`XLEN/8-1:0] wbs_sel_i;
   logic               wbs_stb_i;
   logic               wbs_ack_o;
   logic               wbs_err_o;
   logic               wbs_cyc_i;
   logic               wbs_stall_o;

   modport master (
      output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
      input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_stall_o
   );

   modport slave (
      input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
      output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_stall_o
   );
endinterface

// File: rtl/mr_wb_sram.sv
// Pipelined Wishbone B4 responder over a word-organised RAM: fixed-latency ack/err,
// byte-lane writes, error on out-of-range addresses, optional LFSR-driven stall.
`ifndef XLEN
`define XLEN 32
`endif

module mr_wb_sram #(
   parameter int         ADDR_BITS  = 12,
   parameter int         LATENCY    = 1,
   parameter bit         STALL_LFSR = 1'b0,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   mr_wb_sram_if.slave wbs
);
   localparam int XLEN  = `XLEN;
   localparam int NB    = XLEN / 8;
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [XLEN-1:0]      mem [DEPTH];
   logic [7:0]           lfsr;
   logic                 stall;
   logic                 accept;
   logic                 oor;
   logic [ADDR_BITS-1:0] idx;
   logic                 wr_en;
   logic                 rd_en;
   logic [LATENCY-1:0]   vld_p;
   logic [LATENCY-1:0]   err_p;
   logic [XLEN-1:0]      dat_p [LATENCY];
   logic                 unused_adr_lsb;

   assign stall          = STALL_LFSR ? lfsr[0] : 1'b0;
   assign accept         = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~stall;
   assign idx            = wbs.wbs_adr_i[ADDR_BITS+1:2];
   assign oor            = |wbs.wbs_adr_i[XLEN-1:ADDR_BITS+2];
   assign wr_en          = accept & wbs.wbs_we_i & ~oor;
   assign rd_en          = accept & ~wbs.wbs_we_i & ~oor;
   assign unused_adr_lsb = ^wbs.wbs_adr_i[1:0];

   // Stage 1 loads on accept, later stages shift; dropping cyc flushes every in-flight response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr  <= LFSR_SEED;
         vld_p <= '0;
         err_p <= '0;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         if (!wbs.wbs_cyc_i) begin
            vld_p <= '0;
            err_p <= '0;
         end else begin
            vld_p[0] <= accept;
            err_p[0] <= accept & oor;
            for (int i = 1; i < LATENCY; i++) begin
               vld_p[i] <= vld_p[i-1];
               err_p[i] <= err_p[i-1];
            end
         end
      end
   end

   // Data stage: RAM and read data carry no reset; the output mux hides stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int n = 0; n < NB; n++) begin
            if (wbs.wbs_sel_i[n]) mem[idx][8*n +: 8] <= wbs.wbs_dat_i[8*n +: 8];
         end
      end
      dat_p[0] <= rd_en ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
         dat_p[i] <= dat_p[i-1];
      end
   end

   assign wbs.wbs_ack_o   = vld_p[LATENCY-1] & ~err_p[LATENCY-1];
   assign wbs.wbs_err_o   = vld_p[LATENCY-1] & err_p[LATENCY-1];
   assign wbs.wbs_dat_o   = (vld_p[LATENCY-1] & ~err_p[LATENCY-1]) ? dat_p[LATENCY-1] : '0;
   assign wbs.wbs_stall_o = stall;
endmodule

// File: tb/tb_mr_wb_sram.sv
// Self-checking bench for mr_wb_sram: four instances (latency 1/3/4 and a stalling one)
// driven one at a time, responses checked against an in-order scoreboard.
module tb_mr_wb_sram;
   localparam logic [7:0] SEED = 8'hA5;

   typedef struct {
      logic        err;
      logic [31:0] dat;
      int unsigned due;
   } exp_t;

   typedef struct {
      bit          cyc;
      bit          stb;
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } op_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        bcast = 1'b0;
   logic [1:0]  cur = 2'd0;
   logic        t_cyc = 1'b0, t_stb = 1'b0, t_we = 1'b0;
   logic [31:0] t_adr = '0, t_dat = '0;
   logic [3:0]  t_sel = '0;

   logic [3:0]  ack_v, err_v, stall_v;
   logic [31:0] dat_v [4];
   logic        m_ack, m_err, m_stall;
   logic [31:0] m_dat;

   exp_t        sb[$];
   op_t         ops[$];
   logic [31:0] mdl [int];
   int          checks = 0;
   int          errors = 0;
   int unsigned edge_n = 0;
   int          n_acc = 0;
   int          n_rsp = 0;

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 2;
   endfunction

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      mr_wb_sram_if bus();
      assign bus.wbs_cyc_i = t_cyc && (bcast || cur == 2'(g));
      assign bus.wbs_stb_i = t_stb && (bcast || cur == 2'(g));
      assign bus.wbs_we_i  = t_we;
      assign bus.wbs_adr_i = t_adr;
      assign bus.wbs_dat_i = t_dat;
      assign bus.wbs_sel_i = t_sel;
      assign ack_v[g]      = bus.wbs_ack_o;
      assign err_v[g]      = bus.wbs_err_o;
      assign stall_v[g]    = bus.wbs_stall_o;
      assign dat_v[g]      = bus.wbs_dat_o;
      mr_wb_sram #(
         .ADDR_BITS (12),
         .LATENCY   (lat_of(g)),
         .STALL_LFSR(g == 3),
         .LFSR_SEED (SEED)
      ) dut (
         .clk(clk),
         .rst(rst),
         .wbs(bus.slave)
      );
   end

   assign m_ack   = ack_v[cur];
   assign m_err   = err_v[cur];
   assign m_stall = stall_v[cur];
   assign m_dat   = dat_v[cur];

   function automatic void add_op(bit cyc, bit stb, bit we, logic [31:0] adr, logic [31:0] dat,
                                  logic [3:0] sel);
      op_t o;
      o.cyc = cyc; o.stb = stb; o.we = we; o.adr = adr; o.dat = dat; o.sel = sel;
      ops.push_back(o);
   endfunction

   function automatic void add_idle(int n);
      for (int i = 0; i < n; i++) add_op(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endfunction

   // Reference model for the coming edge: decides acceptance and queues the expected response.
   task automatic model_edge(output bit acc);
      exp_t        e;
      int          key;
      logic [31:0] w;
      acc = t_cyc && t_stb && !m_stall;
      if (!t_cyc) sb.delete();
      if (acc) begin
         n_acc++;
         key   = int'(cur) * 65536 + int'(t_adr[13:2]);
         e.due = edge_n + lat_of(int'(cur));
         e.err = |t_adr[31:14];
         e.dat = 32'h0;
         if (!e.err) begin
            if (t_we) begin
               w = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
               for (int n = 0; n < 4; n++) if (t_sel[n]) w[8*n +: 8] = t_dat[8*n +: 8];
               mdl[key] = w;
            end else begin
               e.dat = mdl[key];
            end
         end
         sb.push_back(e);
      end
   endtask

   task automatic test_reset();
      bcast = 1'b1;
      rst   = 1'b0;
      for (int c = 0; c < 6; c++) begin
         t_cyc = 1'($urandom); t_stb = 1'($urandom); t_we = 1'($urandom);
         t_adr = $urandom;     t_dat = $urandom;     t_sel = 4'($urandom);
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            checks++;
            if (ack_v[g] !== 1'b0 || err_v[g] !== 1'b0 || dat_v[g] !== 32'h0 ||
                stall_v[g] !== ((g == 3) ? SEED[0] : 1'b0)) begin
               errors++;
               $display("FAIL reset_hold dut%0d: ack=%b err=%b dat=%h stall=%b, required 0 0 0 %b",
                        g, ack_v[g], err_v[g], dat_v[g], stall_v[g], (g == 3) ? SEED[0] : 1'b0);
            end
         end
      end
      t_cyc = 1'b0; t_stb = 1'b0; bcast = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (stall_v[3] !== 1'b0) begin
         errors++; $display("FAIL lfsr_step1: stall=%b, required 0", stall_v[3]);
      end
      @(posedge clk); #1;
      checks++;
      if (stall_v[3] !== 1'b1) begin
         errors++; $display("FAIL lfsr_step2: stall=%b, required 1", stall_v[3]);
      end
   endtask

   task automatic test_byte_lane();
      exp_t e;
      bit   acc;
      cur = 2'd0; ops.delete(); sb.delete();
      add_op(1, 1, 1, 32'h10, 32'hDEADBEEF, 4'b1111);
      add_op(1, 1, 1, 32'h10, 32'h000000AA, 4'b0001);
      add_op(1, 1, 0, 32'h10, 32'h0, 4'b0000);
      add_op(1, 1, 1, 32'h14, 32'h0, 4'b1111);
      add_op(1, 1, 1, 32'h14, 32'h11223344, 4'b1010);
      add_op(1, 1, 1, 32'h16, 32'hFFFFFFFF, 4'b0000);
      add_op(1, 1, 0, 32'h17, 32'h0, 4'b0001);
      add_idle(3);
      foreach (ops[i]) begin
         t_cyc = ops[i].cyc; t_stb = ops[i].stb; t_we = ops[i].we;
         t_adr = ops[i].adr; t_dat = ops[i].dat; t_sel = ops[i].sel;
         model_edge(acc);
         @(posedge clk); #1;
         if (m_ack !== 1'b0 || m_err !== 1'b0 || m_dat !== 32'h0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL byte_lane_resp: ack=%b err=%b dat=%h, required no response", m_ack, m_err, m_dat);
            end else begin
               e = sb.pop_front(); n_rsp++;
               if (m_ack !== !e.err || m_err !== e.err || m_dat !== e.dat || edge_n != e.due) begin
                  errors++;
                  $display("FAIL byte_lane_resp: ack=%b err=%b dat=%h edge=%0d, required ack=%b err=%b dat=%h edge=%0d",
                           m_ack, m_err, m_dat, edge_n, !e.err, e.err, e.dat, e.due);
               end
            end
         end else if (sb.size() != 0 && sb[0].due <= edge_n) begin
            checks++; errors++;
            $display("FAIL byte_lane_missing: no response at edge %0d, required one due at %0d", edge_n, sb[0].due);
            void'(sb.pop_front());
         end
      end
      t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h10; t_sel = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (m_ack !== 1'b1 || m_err !== 1'b0 || m_dat !== 32'hDEADBEAA) begin
         errors++;
         $display("FAIL byte_lane_readback: ack=%b err=%b dat=%h, required 1 0 deadbeaa", m_ack, m_err, m_dat);
      end
      t_stb = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (m_ack !== 1'b0 || m_dat !== 32'h0) begin
         errors++; $display("FAIL byte_lane_pulse: ack=%b dat=%h, required 0 0", m_ack, m_dat);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit   acc;
      cur = 2'd1; ops.delete(); sb.delete();
      for (int i = 0; i < 8; i++) add_op(1, 1, 1, 32'(i * 4), $urandom, 4'b1111);
      add_idle(2);
      for (int i = 0; i < 8; i++) add_op(1, 1, 0, 32'(i * 4), 32'h0, 4'($urandom));
      add_idle(5);
      foreach (ops[i]) begin
         t_cyc = ops[i].cyc; t_stb = ops[i].stb; t_we = ops[i].we;
         t_adr = ops[i].adr; t_dat = ops[i].dat; t_sel = ops[i].sel;
         model_edge(acc);
         @(posedge clk); #1;
         if (m_ack !== 1'b0 || m_err !== 1'b0 || m_dat !== 32'h0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL burst_resp: ack=%b err=%b dat=%h, required no response", m_ack, m_err, m_dat);
            end else begin
               e = sb.pop_front(); n_rsp++;
               if (m_ack !== !e.err || m_err !== e.err || m_dat !== e.dat || edge_n != e.due) begin
                  errors++;
                  $display("FAIL burst_resp: ack=%b err=%b dat=%h edge=%0d, required ack=%b err=%b dat=%h edge=%0d",
                           m_ack, m_err, m_dat, edge_n, !e.err, e.err, e.dat, e.due);
               end
            end
         end else if (sb.size() != 0 && sb[0].due <= edge_n) begin
            checks++; errors++;
            $display("FAIL burst_missing: no response at edge %0d, required one due at %0d", edge_n, sb[0].due);
            void'(sb.pop_front());
         end
      end
   endtask

   task automatic test_reset_mid();
      cur = 2'd1; sb.delete();
      t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h0;
      @(posedge clk); #1;
      t_adr = 32'h4;
      @(posedge clk); #1;
      t_stb = 1'b0;
      @(negedge clk); rst = 1'b0; #1;
      checks++;
      if (m_ack !== 1'b0 || m_err !== 1'b0 || m_dat !== 32'h0) begin
         errors++; $display("FAIL reset_mid_async: ack=%b err=%b dat=%h, required 0 0 0", m_ack, m_err, m_dat);
      end
      @(negedge clk); rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if (m_ack !== 1'b0 || m_err !== 1'b0 || m_dat !== 32'h0) begin
            errors++; $display("FAIL reset_mid_flush: ack=%b err=%b dat=%h, required 0 0 0", m_ack, m_err, m_dat);
         end
      end
   endtask

   task automatic test_out_of_range();
      exp_t e;
      bit   acc;
      cur = 2'd0; ops.delete(); sb.delete();
      add_op(1, 1, 1, 32'h0000_0000, 32'h12345678, 4'b1111);
      add_op(1, 1, 0, 32'h0000_4000, 32'h0, 4'b1111);
      add_op(1, 1, 1, 32'h0000_4000, 32'h00000055, 4'b1111);
      add_op(1, 1, 0, 32'h0000_0000, 32'h0, 4'b1111);
      add_op(1, 1, 0, 32'hFFFF_FFFC, 32'h0, 4'b1111);
      add_op(1, 1, 0, 32'h0000_3FFC, 32'h0, 4'b1111);
      add_op(1, 1, 1, 32'h0000_3FFC, 32'hCAFEF00D, 4'b1111);
      add_op(1, 1, 0, 32'h0000_3FFC, 32'h0, 4'b1111);
      add_idle(3);
      foreach (ops[i]) begin
         t_cyc = ops[i].cyc; t_stb = ops[i].stb; t_we = ops[i].we;
         t_adr = ops[i].adr; t_dat = ops[i].dat; t_sel = ops[i].sel;
         model_edge(acc);
         @(posedge clk); #1;
         if (m_ack !== 1'b0 || m_err !== 1'b0 || m_dat !== 32'h0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL oor_resp: ack=%b err=%b dat=%h, required no response", m_ack, m_err, m_dat);
            end else begin
               e = sb.pop_front(); n_rsp++;
               if (m_ack !== !e.err || m_err !== e.err || m_dat !== e.dat || edge_n != e.due) begin
                  errors++;
                  $display("FAIL oor_resp: ack=%b err=%b dat=%h edge=%0d, required ack=%b err=%b dat=%h edge=%0d",
                           m_ack, m_err, m_dat, edge_n, !e.err, e.err, e.dat, e.due);
               end
            end
         end else if (sb.size() != 0 && sb[0].due <= edge_n) begin
            checks++; errors++;
            $display("FAIL oor_missing: no response at edge %0d, required one due at %0d", edge_n, sb[0].due);
            void'(sb.pop_front());
         end
      end
   endtask

   task automatic test_cycle_abort();
      exp_t e;
      bit   acc;
      cur = 2'd2; ops.delete(); sb.delete();
      add_op(1, 1, 1, 32'h80, 32'hA1A2A3A4, 4'b1111);
      add_op(1, 1, 1, 32'h84, 32'hB1B2B3B4, 4'b1111);
      add_op(1, 1, 1, 32'h88, 32'hC1C2C3C4, 4'b1111);
      for (int i = 0; i < 6; i++) add_op(0, 0, 0, 32'h0, 32'h0, 4'h0);
      add_op(1, 1, 0, 32'h80, 32'h0, 4'b1111);
      add_op(1, 1, 0, 32'h84, 32'h0, 4'b1111);
      add_op(1, 1, 0, 32'h88, 32'h0, 4'b1111);
      add_idle(6);
      foreach (ops[i]) begin
         t_cyc = ops[i].cyc; t_stb = ops[i].stb; t_we = ops[i].we;
         t_adr = ops[i].adr; t_dat = ops[i].dat; t_sel = ops[i].sel;
         model_edge(acc);
         @(posedge clk); #1;
         if (m_ack !== 1'b0 || m_err !== 1'b0 || m_dat !== 32'h0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL abort_resp: ack=%b err=%b dat=%h, required no response", m_ack, m_err, m_dat);
            end else begin
               e = sb.pop_front(); n_rsp++;
               if (m_ack !== !e.err || m_err !== e.err || m_dat !== e.dat || edge_n != e.due) begin
                  errors++;
                  $display("FAIL abort_resp: ack=%b err=%b dat=%h edge=%0d, required ack=%b err=%b dat=%h edge=%0d",
                           m_ack, m_err, m_dat, edge_n, !e.err, e.err, e.dat, e.due);
               end
            end
         end else if (sb.size() != 0 && sb[0].due <= edge_n) begin
            checks++; errors++;
            $display("FAIL abort_missing: no response at edge %0d, required one due at %0d", edge_n, sb[0].due);
            void'(sb.pop_front());
         end
      end
   endtask

   task automatic test_stall_stress();
      exp_t e;
      bit   acc;
      bit   hold;
      bit   saw_hi = 1'b0, saw_lo = 1'b0;
      int   w;
      cur = 2'd3; sb.delete();
      n_acc = 0; n_rsp = 0;
      for (int i = 0; i < 16 + 200 + 8; i++) begin
         hold  = (i < 216);
         t_cyc = 1'b1;
         t_stb = hold;
         if (i < 16) begin
            t_we = 1'b1; t_adr = 32'(i * 4); t_dat = $urandom; t_sel = 4'b1111;
         end else if (hold) begin
            t_we  = 1'($urandom);
            t_dat = $urandom;
            t_sel = 4'($urandom);
            if ($urandom_range(0, 19) == 0) t_adr = {16'($urandom_range(1, 65535)), 16'($urandom)};
            else t_adr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
         end
         w = 0;
         do begin
            model_edge(acc);
            if (m_stall) saw_hi = 1'b1; else saw_lo = 1'b1;
            @(posedge clk); #1;
            w++;
            if (m_ack !== 1'b0 || m_err !== 1'b0 || m_dat !== 32'h0) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL stall_resp: ack=%b err=%b dat=%h, required no response", m_ack, m_err, m_dat);
               end else begin
                  e = sb.pop_front(); n_rsp++;
                  if (m_ack !== !e.err || m_err !== e.err || m_dat !== e.dat || edge_n != e.due) begin
                     errors++;
                     $display("FAIL stall_resp: ack=%b err=%b dat=%h edge=%0d, required ack=%b err=%b dat=%h edge=%0d",
                              m_ack, m_err, m_dat, edge_n, !e.err, e.err, e.dat, e.due);
                  end
               end
            end else if (sb.size() != 0 && sb[0].due <= edge_n) begin
               checks++; errors++;
               $display("FAIL stall_missing: no response at edge %0d, required one due at %0d", edge_n, sb[0].due);
               void'(sb.pop_front());
            end
         end while (hold && !acc && w < 64);
         if (hold && !acc) begin
            checks++; errors++;
            $display("FAIL stall_timeout: request %0d not accepted in 64 cycles, required acceptance", i);
         end
      end
      t_stb = 1'b0;
      checks++;
      if (n_rsp != n_acc || sb.size() != 0) begin
         errors++;
         $display("FAIL stall_count: responses=%0d pending=%0d, required responses=%0d pending=0",
                  n_rsp, sb.size(), n_acc);
      end
      checks++;
      if (!(saw_hi && saw_lo)) begin
         errors++; $display("FAIL stall_activity: saw_hi=%b saw_lo=%b, required 1 1", saw_hi, saw_lo);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_byte_lane();
      test_back_to_back();
      test_reset_mid();
      test_out_of_range();
      test_cycle_abort();
      test_stall_stress();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
